pwm_ramp_ctrl: RTL and testbench

//  Sequencer for the PWM generator datapath. Consumes the single-cycle enable

---
 rtl/pwm_ramp_ctrl_pkg.sv | 15 +
 rtl/pwm_period_cnt.sv | 41 ++++
 rtl/pwm_ramp_ctrl.sv | 120 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared definitions for the PWM ramp controller: FSM state encodings and
// default geometry reused by the PWM generator top.
package pwm_ramp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RAMP = 2'd2
  } state_e;

  localparam int DEF_W      = 8;
  localparam int DEF_PERIOD = 255;
  localparam int DEF_STEP   = 1;

endpackage

// File: rtl/pwm_period_cnt.sv
// Tick-enabled 0..PERIOD period counter with synchronous clear, a look-ahead
// next-count output and a single-cycle wrap pulse marking the period end.
module pwm_period_cnt #(
  parameter int W      = 8,
  parameter int PERIOD = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] PERIOD_W = W'(PERIOD);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == PERIOD_W);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    cnt_next_o = r_cnt;
    if (clr_i)       cnt_next_o = '0;
    else if (tick_i) cnt_next_o = w_last ? '0 : r_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= cnt_next_o;
  end

  assign cnt_o  = r_cnt;
  assign wrap_o = tick_i && !clr_i && w_last;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM sequencer: runs the period counter, accepts duty setpoints by valid/ready
// and soft-ramps the applied duty by STEP counts at each period end.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int PERIOD = DEF_PERIOD,
  parameter int STEP   = DEF_STEP
) (
  input  logic         cLocK,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic         en_i,
  input  logic         duty_vld_i,
  input  logic [W-1:0] duty_i,
  output logic         duty_rdy_o,
  output logic         pwm_o,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] duty_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [W-1:0] PERIOD_W = W'(PERIOD);
  localparam logic [W-1:0] STEP_W   = W'(STEP);
  localparam logic [W:0]   STEP_X   = (W+1)'(STEP);

  state_e       r_state, w_state_next;
  logic [W-1:0] r_cur_duty, r_target, r_pwm;
  logic         r_done;

  logic [W-1:0] w_duty_next, w_target_next, w_cnt_next, w_clamped, w_step_val;
  logic         w_done_next, w_wrap, w_clr, w_accept;
  logic [W:0]   w_cur_x, w_tgt_x, w_up_x, w_dn_lim_x;

  // The counter sits at 0 in OFF and is cleared on the edge that enters OFF.
  assign w_clr = (r_state == ST_OFF) || !en_i;

  pwm_period_cnt #(.W(W), .PERIOD(PERIOD)) u_cnt (
    .clk        (cLocK),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .clr_i      (w_clr),
    .cnt_o      (cnt_o),
    .cnt_next_o (w_cnt_next),
    .wrap_o     (w_wrap)
  );

  assign w_accept  = duty_vld_i && duty_rdy_o;
  assign w_clamped = (duty_i > PERIOD_W) ? PERIOD_W : duty_i;

  // One-bit-wider arithmetic so cur+STEP and target+STEP cannot wrap.
  assign w_cur_x    = {1'b0, r_cur_duty};
  assign w_tgt_x    = {1'b0, r_target};
  assign w_up_x     = w_cur_x + STEP_X;
  assign w_dn_lim_x = w_tgt_x + STEP_X;

  always_comb begin
    w_step_val = r_target;
    if (r_cur_duty < r_target)
      w_step_val = (w_up_x >= w_tgt_x) ? r_target : r_cur_duty + STEP_W;
    else if (r_cur_duty > r_target)
      w_step_val = (w_cur_x <= w_dn_lim_x) ? r_target : r_cur_duty - STEP_W;
  end

  always_comb begin
    w_state_next  = r_state;
    w_duty_next   = r_cur_duty;
    w_target_next = r_target;
    w_done_next   = 1'b0;
    if (!en_i) begin
      w_state_next  = ST_OFF;
      w_target_next = r_cur_duty;
    end else begin
      unique case (r_state)
        ST_OFF: w_state_next = ST_IDLE;
        ST_IDLE: if (w_accept) begin
          w_target_next = w_clamped;
          if (w_clamped == r_cur_duty) w_done_next  = 1'b1;
          else                         w_state_next = ST_RAMP;
        end
        ST_RAMP: if (w_wrap) begin
          w_duty_next = w_step_val;
          if (w_step_val == r_target) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
        default: w_state_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge cLocK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_cur_duty <= '0;
      r_target   <= '0;
      r_pwm      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cur_duty <= w_duty_next;
      r_target   <= w_target_next;
      r_pwm      <= {{(W-1){1'b0}}, en_i && (w_cnt_next < w_duty_next)};
      r_done     <= w_done_next;
    end
  end

  assign pwm_o      = r_pwm[0];
  assign duty_o     = r_cur_duty;
  assign duty_rdy_o = (r_state == ST_IDLE);
  assign busy_o     = (r_state == ST_RAMP);
  assign done_o     = r_done;

  // Upper bits of r_pwm are constant zero; fold them in so they count as used.
  logic w_pwm_hi_unused;
  assign w_pwm_hi_unused = |r_pwm[W-1:1];

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with W=8, PERIOD=9, STEP=2 and a divide-by-3
// tick source; every expectation below is a hand-computed constant.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick;
  logic       en = 1'b0;
  logic       duty_vld = 1'b0;
  logic [7:0] duty_in = '0;
  logic       duty_rdy, pwm, busy, done;
  logic [7:0] cnt, duty;

  logic [1:0] div = '0;
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) div <= (div == 2'd2) ? 2'd0 : div + 2'd1;
  assign tick = (div == 2'd2);

  always @(negedge clk) if (done) done_seen++;

  pwm_ramp_ctrl #(.W(8), .PERIOD(9), .STEP(2)) dut (
    .cLocK      (clk),
    .rst_n      (rst_n),
    .tick_i     (tick),
    .en_i       (en),
    .duty_vld_i (duty_vld),
    .duty_i     (duty_in),
    .duty_rdy_o (duty_rdy),
    .pwm_o      (pwm),
    .cnt_o      (cnt),
    .duty_o     (duty),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_duty(input string tag, input logic [7:0] exp);
    logic [7:0] old;
    old = duty;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (duty != old) break;
    end
    check(tag, duty, exp);
  endtask

  task automatic accept(input string tag, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    duty_vld = 1'b1;
    duty_in  = d;
    for (int i = 0; i < 200; i++) begin
      if (duty_rdy) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    duty_vld = 1'b0;
    check(tag, ok, 1);
  endtask

  task automatic count_pwm(input string tag, input int exp);
    int hi;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (pwm) hi++;
    end
    check(tag, hi, exp);
  endtask

  initial begin
    // Reset state and release
    #2;
    check("rst_pwm", pwm, 0);
    check("rst_cnt", cnt, 0);
    check("rst_duty", duty, 0);
    check("rst_rdy", duty_rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_rdy_low", duty_rdy, 0);
    @(negedge clk);
    check("rel_rdy_high", duty_rdy, 1);

    // Ramp up 0 -> 7
    done_seen = 0;
    accept("acc7", 8'd7);
    check("ramp7_busy", busy, 1);
    check("ramp7_rdy", duty_rdy, 0);
    wait_duty("up_2", 8'd2);
    wait_duty("up_4", 8'd4);
    wait_duty("up_6", 8'd6);
    check("up_6_no_done", done, 0);
    wait_duty("up_7", 8'd7);
    check("up_7_done", done, 1);
    check("up_7_busy", busy, 0);
    @(negedge clk);
    check("up_7_done_clr", done, 0);
    repeat (3) @(negedge clk);
    check("up_done_once", done_seen, 1);
    count_pwm("pwm_7of10", 21);

    // Clamp to PERIOD, then ramp down to 0
    accept("acc200", 8'd200);
    wait_duty("clamp_9", 8'd9);
    @(negedge clk);
    check("clamp_idle", duty_rdy, 1);
    count_pwm("pwm_9of10", 27);
    accept("acc0", 8'd0);
    wait_duty("dn_7", 8'd7);
    wait_duty("dn_5", 8'd5);
    wait_duty("dn_3", 8'd3);
    wait_duty("dn_1", 8'd1);
    wait_duty("dn_0", 8'd0);
    @(negedge clk);
    count_pwm("pwm_zero", 0);

    // Equal setpoint: no ramp, done next cycle
    accept("acc_eq", 8'd0);
    check("eq_done", done, 1);
    check("eq_busy", busy, 0);
    check("eq_rdy", duty_rdy, 1);
    @(negedge clk);
    check("eq_done_clr", done, 0);
    check("eq_busy2", busy, 0);

    // Disable mid-ramp
    accept("acc8", 8'd8);
    wait_duty("dis_2", 8'd2);
    wait_duty("dis_4", 8'd4);
    done_seen = 0;
    en = 1'b0;
    @(negedge clk);
    check("off_pwm", pwm, 0);
    check("off_cnt", cnt, 0);
    check("off_duty", duty, 4);
    check("off_busy", busy, 0);
    check("off_rdy", duty_rdy, 0);
    repeat (20) @(negedge clk);
    check("off_cnt_held", cnt, 0);
    check("off_no_done", done_seen, 0);
    en = 1'b1;
    @(negedge clk);
    check("reen_rdy", duty_rdy, 1);
    repeat (70) @(negedge clk);
    check("reen_duty", duty, 4);
    check("reen_busy", busy, 0);
    check("reen_no_done", done_seen, 0);

    // Valid held through RAMP
    accept("acc8b", 8'd8);
    duty_vld = 1'b1;
    duty_in  = 8'd3;
    check("hold_rdy0", duty_rdy, 0);
    wait_duty("hold_6", 8'd6);
    check("hold_busy", busy, 1);
    wait_duty("hold_8", 8'd8);
    check("hold_first_idle", duty_rdy, 1);
    check("hold_done", done, 1);
    @(negedge clk);
    check("hold_accepted", busy, 1);
    duty_vld = 1'b0;
    wait_duty("hold_dn6", 8'd6);
    wait_duty("hold_dn4", 8'd4);
    wait_duty("hold_dn3", 8'd3);

    // Reset mid-ramp
    accept("acc9", 8'd9);
    wait_duty("mid_5", 8'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_duty", duty, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cnt", cnt, 0);
    check("mrst_pwm", pwm, 0);
    check("mrst_rdy", duty_rdy, 0);
    check("mrst_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
